mips_cpu_lsu: RTL

Parametrised load/store unit between the multi-cycle MIPS core and the Avalon-MM data bus. It takes one memory request at a time from the core FSM and runs the bus cycle, holding through waitrequest and an optional fixed read latency. It performs byte-lane steering, byteenable generation, sign/zero extension and LWL/LWR merging, and reports misalignment and bus-timeout errors. It replaces the ad-hoc load/store logic embedded in the CPU top level.

---
 rtl/mips_cpu_lsu_pkg.sv | 13 +
 rtl/mips_cpu_lsu_align.sv | 54 +++++
 rtl/mips_cpu_lsu.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_cpu_lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_lsu_pkg : shared types for the MIPS load/store unit        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
package mips_cpu_lsu_pkg;
  typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} lsu_size_t;
  typedef enum logic [1:0] {NORMAL = 2'd0, LWL = 2'd1, LWR = 2'd2} lsu_mode_t;
  // Prefixed so the TIMEOUT member never collides with the top-level TIMEOUT parameter.
  typedef enum logic [1:0] {ERR_OK = 2'd0, ERR_MISALIGN = 2'd1, ERR_TIMEOUT = 2'd2} lsu_err_t;
  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RDWAIT = 2'd2, RESP = 2'd3} lsu_state_t;
endpackage
`default_nettype wire

// File: rtl/mips_cpu_lsu_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_lsu_align : lane steering, byteenables, load extend/merge  |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mips_cpu_lsu_align
  import mips_cpu_lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  mode,
  input  logic [1:0]  offset,
  input  logic        is_signed,
  input  logic [31:0] wdata,
  input  logic [31:0] rd,
  input  logic [31:0] rt_old,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  output logic [31:0] rdata
);
  logic [5:0]  w_sh_k;
  logic [31:0] w_lane;

  assign w_sh_k = {1'b0, offset, 3'b000};
  assign w_lane = rd >> w_sh_k;

  always_comb begin
    byteenable = 4'b1111;
    writedata  = wdata;
    rdata      = rd;
    if (mode == LWL) begin
      byteenable = 4'b1111 >> (~offset);
      // A shift of 32 (offset 3) clears the keep mask, so all of rt_old is replaced.
      rdata = (rd << {1'b0, ~offset, 3'b000}) | (rt_old & (32'hFFFF_FFFF >> (w_sh_k + 6'd8)));
    end else if (mode == LWR) begin
      byteenable = 4'b1111 << offset;
      rdata = w_lane | (rt_old & ~(32'hFFFF_FFFF >> w_sh_k));
    end else begin
      case (size)
        BYTE: begin
          byteenable = 4'b0001 << offset;
          writedata  = {4{wdata[7:0]}};
          rdata      = {{24{is_signed & w_lane[7]}}, w_lane[7:0]};
        end
        HALF: begin
          byteenable = offset[1] ? 4'b1100 : 4'b0011;
          writedata  = {2{wdata[15:0]}};
          rdata      = {{16{is_signed & w_lane[15]}}, w_lane[15:0]};
        end
        default: ;
      endcase
    end
  end
endmodule
`default_nettype wire

// File: rtl/mips_cpu_lsu.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | mips_cpu_lsu : single-request load/store unit onto Avalon-MM        |
// | Revision 1.0                                                       |
// +--------------------------------------------------------------------+
module mips_cpu_lsu
  import mips_cpu_lsu_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [1:0]        req_mode,
  input  logic [31:0]       req_wdata,
  input  logic [31:0]       req_rt_old,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic [1:0]        resp_err,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  output logic              write,
  input  logic              waitrequest,
  output logic [31:0]       writedata,
  output logic [3:0]        byteenable,
  input  logic [31:0]       readdata
);
  localparam logic [31:0] C_LAT_LOAD = 32'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [31:0] C_TO_LAST  = 32'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_t  r_state;
  logic        r_is_write, r_signed;
  logic [1:0]  r_size, r_mode, r_off;
  logic [31:0] r_rt_old, r_wait_cnt, r_lat_cnt;

  logic        w_idle, w_illegal;
  logic [1:0]  w_size, w_mode, w_off;
  logic [3:0]  w_be;
  logic [31:0] w_wd, w_rdata, w_rt_old;

  assign w_idle    = (r_state == IDLE);
  assign req_ready = w_idle;

  // Store lanes are built from the live request; load results use the captured one.
  assign w_size   = w_idle ? req_size      : r_size;
  assign w_mode   = w_idle ? req_mode      : r_mode;
  assign w_off    = w_idle ? req_addr[1:0] : r_off;
  assign w_rt_old = w_idle ? req_rt_old    : r_rt_old;

  assign w_illegal = (req_size == 2'd3) || (req_mode == 2'd3)
                   || ((req_mode != NORMAL) && (req_write || (req_size != WORD)))
                   || ((req_size == HALF) && req_addr[0])
                   || ((req_size == WORD) && (req_mode == NORMAL) && (req_addr[1:0] != 2'd0));

  mips_cpu_lsu_align u_align (
    .size       (w_size),
    .mode       (w_mode),
    .offset     (w_off),
    .is_signed  (w_idle ? req_signed : r_signed),
    .wdata      (req_wdata),
    .rd         (readdata),
    .rt_old     (w_rt_old),
    .byteenable (w_be),
    .writedata  (w_wd),
    .rdata      (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      read       <= 1'b0;
      write      <= 1'b0;
      resp_valid <= 1'b0;
      resp_err   <= ERR_OK;
      resp_rdata <= '0;
      byteenable <= 4'b1111;
      address    <= '0;
      writedata  <= '0;
      r_is_write <= 1'b0;
      r_signed   <= 1'b0;
      r_size     <= '0;
      r_mode     <= '0;
      r_off      <= '0;
      r_rt_old   <= '0;
      r_wait_cnt <= '0;
      r_lat_cnt  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        IDLE: if (req_valid) begin
          r_is_write <= req_write;
          r_signed   <= req_signed;
          r_size     <= req_size;
          r_mode     <= req_mode;
          r_off      <= req_addr[1:0];
          r_rt_old   <= req_rt_old;
          r_wait_cnt <= '0;
          if (w_illegal) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_MISALIGN;
            resp_rdata <= '0;
          end else begin
            r_state    <= BUS;
            read       <= ~req_write;
            write      <= req_write;
            address    <= {req_addr[ADDR_W-1:2], 2'b00};
            byteenable <= w_be;
            writedata  <= w_wd;
          end
        end
        BUS: if (!waitrequest) begin
          read  <= 1'b0;
          write <= 1'b0;
          if (r_is_write) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= '0;
          end else if (READ_LATENCY == 0) begin
            r_state    <= RESP;
            resp_valid <= 1'b1;
            resp_err   <= ERR_OK;
            resp_rdata <= w_rdata;
          end else begin
            r_state   <= RDWAIT;
            r_lat_cnt <= C_LAT_LOAD;
          end
        end else if ((TIMEOUT != 0) && (r_wait_cnt == C_TO_LAST)) begin
          read       <= 1'b0;
          write      <= 1'b0;
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= ERR_TIMEOUT;
          resp_rdata <= '0;
        end else begin
          r_wait_cnt <= r_wait_cnt + 32'd1;
        end
        RDWAIT: if (r_lat_cnt == '0) begin
          r_state    <= RESP;
          resp_valid <= 1'b1;
          resp_err   <= ERR_OK;
          resp_rdata <= w_rdata;
        end else begin
          r_lat_cnt <= r_lat_cnt - 32'd1;
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
